interrupt_sequence_controller: RTL and testbench

- Sequences the in-service register datapath of the 8259A-style controller.
- Resolves the highest-priority unmasked request under the current rotation and raises INT.
- Runs the two-pulse INTA handshake (8086 mode): latches the winner into the ISR, then returns the vector.
- Generates end-of-interrupt clears and priority-rotation updates for EOI commands (auto, non-specific, specific).

---
 rtl/interrupt_sequence_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_interrupt_sequence_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequence_controller.sv
// Interrupt sequence controller for an 8259A-style PIC (8086 mode).
// Arbitrates pending requests under the current rotation and raises INT.
// Runs the two-pulse INTA handshake: latches the winner into the ISR, then
// presents {vector_base, level}.
// Produces ISR clear pulses and rotation updates for automatic and commanded EOI.
module interrupt_sequence_controller #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic [7:0] in_service_register,
  input  logic [2:0] priority_rotate,
  input  logic       special_mask_mode,
  input  logic       auto_eoi,
  input  logic       auto_rotate,
  input  logic [4:0] vector_base,
  input  logic       inta_n,
  input  logic       eoi_command,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
  output logic       interrupt_out,
  output logic       latch_in_service,
  output logic [7:0] acknowledged_level,
  output logic [7:0] end_of_interrupt,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  output logic       rotate_update,
  output logic [2:0] new_priority_rotate
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK1,
    ST_ACK2,
    ST_AEOI
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic       inta_q;
  logic       inta_fall;
  logic       inta_rise;

  logic       int_q;
  logic       latch_q;
  logic [7:0] ack_q;
  logic [2:0] lvl_q;
  logic       spur_q;
  logic [7:0] eoi_q;
  logic       rot_upd_q;
  logic [2:0] rot_lvl_q;

  logic [7:0] candidate;
  logic [3:0] win_scan;
  logic       win_found;
  logic [2:0] win_lvl;
  logic [3:0] ns_scan;

  logic       take_ack;
  logic       aeoi_go;
  logic [7:0] cmd_clear;
  logic       cmd_rot_vld;
  logic [2:0] cmd_rot_lvl;

  // Walks the eight levels from highest priority (rot+1) downwards. A level set
  // in 'block' ends the walk (nothing at or below it may win); the first level
  // set in 'cand' before that point wins. Returns {found, level}.
  function automatic logic [3:0] scan_priority(input logic [7:0] cand,
                                               input logic [7:0] block,
                                               input logic [2:0] rot);
    logic       done;
    logic [3:0] res;
    logic [2:0] lvl;
    res  = 4'd0;
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lvl = rot + 3'd1 + 3'(i);
      if (!done) begin
        if (block[lvl]) begin
          done = 1'b1;
        end else if (cand[lvl]) begin
          res  = {1'b1, lvl};
          done = 1'b1;
        end
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] one_hot(input logic [2:0] lvl);
    return 8'd1 << lvl;
  endfunction

  // Priority resolution: in normal mode the highest in-service level blocks
  // itself and everything below it; in special mask mode an in-service level
  // only removes itself from contention.
  always_comb begin
    candidate = interrupt_request_register & ~interrupt_mask;
    if (special_mask_mode)
      win_scan = scan_priority(candidate & ~in_service_register, 8'h00, priority_rotate);
    else
      win_scan = scan_priority(candidate, in_service_register, priority_rotate);
    win_found = win_scan[3];
    win_lvl   = win_scan[2:0];
    ns_scan   = scan_priority(in_service_register, 8'h00, priority_rotate);
    inta_fall = inta_q & ~inta_n;
    inta_rise = ~inta_q & inta_n;
  end

  // Next-state and handshake decisions.
  always_comb begin
    state_d  = state_q;
    take_ack = 1'b0;
    aeoi_go  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (inta_fall) begin
          state_d  = ST_ACK1;
          take_ack = 1'b1;
        end else if (!win_found) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK1: begin
        if (inta_fall) state_d = ST_ACK2;
      end
      ST_ACK2: begin
        if (inta_rise) begin
          if (auto_eoi && !spur_q) begin
            state_d = ST_AEOI;
            aeoi_go = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_AEOI: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decode an OCW2 EOI strobe into the ISR bit to clear and optional rotation.
  always_comb begin
    cmd_clear   = 8'h00;
    cmd_rot_vld = 1'b0;
    cmd_rot_lvl = 3'd0;
    if (eoi_command) begin
      if (eoi_specific) begin
        cmd_clear   = one_hot(eoi_level);
        cmd_rot_vld = eoi_rotate;
        cmd_rot_lvl = eoi_level;
      end else if (ns_scan[3]) begin
        cmd_clear   = one_hot(ns_scan[2:0]);
        cmd_rot_vld = eoi_rotate;
        cmd_rot_lvl = ns_scan[2:0];
      end
    end
  end

  // State register, INTA sampler and handshake outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      inta_q  <= 1'b1;
      int_q   <= 1'b0;
      latch_q <= 1'b0;
      ack_q   <= 8'h00;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inta_q  <= inta_n;
      int_q   <= (state_q == ST_REQ) && (state_d == ST_REQ);
      latch_q <= take_ack && win_found;
      if (take_ack) begin
        ack_q  <= win_found ? one_hot(win_lvl) : 8'h00;
        spur_q <= ~win_found;
      end
    end
  end

  // Acknowledged level for the vector; only observed while the vector is valid.
  always_ff @(posedge clock) begin
    if (take_ack) lvl_q <= win_found ? win_lvl : SPURIOUS_LEVEL;
  end

  // EOI clear and rotation pulses; a commanded rotation overrides the automatic one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eoi_q     <= 8'h00;
      rot_upd_q <= 1'b0;
      rot_lvl_q <= 3'd0;
    end else begin
      eoi_q <= cmd_clear | (aeoi_go ? ack_q : 8'h00);
      if (cmd_rot_vld) begin
        rot_upd_q <= 1'b1;
        rot_lvl_q <= cmd_rot_lvl;
      end else if (aeoi_go && auto_rotate) begin
        rot_upd_q <= 1'b1;
        rot_lvl_q <= lvl_q;
      end else begin
        rot_upd_q <= 1'b0;
        rot_lvl_q <= 3'd0;
      end
    end
  end

  assign interrupt_out       = int_q;
  assign latch_in_service    = latch_q;
  assign acknowledged_level  = ack_q;
  assign end_of_interrupt    = eoi_q;
  assign vector_valid        = (state_q == ST_ACK2);
  assign vector_out          = vector_valid ? {vector_base, lvl_q} : 8'h00;
  assign rotate_update       = rot_upd_q;
  assign new_priority_rotate = rot_lvl_q;

endmodule

// File: tb/tb_interrupt_sequence_controller.sv
// Self-checking bench for interrupt_sequence_controller: directed table,
// hand-written corner sequences and randomized vectors against a rank-based model.
module tb_interrupt_sequence_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] irr, mask, isr;
  logic [2:0] rot;
  logic       smm, aeoi, arot;
  logic [4:0] vbase;
  logic       inta_n, eoi_cmd, eoi_spec, eoi_rot;
  logic [2:0] eoi_lvl;
  logic       int_out, latch;
  logic [7:0] ack_level, eoi_out, vec;
  logic       vec_valid, rot_upd;
  logic [2:0] new_rot;

  interrupt_sequence_controller #(.SPURIOUS_LEVEL(3'd7)) dut (
    .clock                      (clock),
    .reset_n                    (reset_n),
    .interrupt_request_register (irr),
    .interrupt_mask             (mask),
    .in_service_register        (isr),
    .priority_rotate            (rot),
    .special_mask_mode          (smm),
    .auto_eoi                   (aeoi),
    .auto_rotate                (arot),
    .vector_base                (vbase),
    .inta_n                     (inta_n),
    .eoi_command                (eoi_cmd),
    .eoi_specific               (eoi_spec),
    .eoi_level                  (eoi_lvl),
    .eoi_rotate                 (eoi_rot),
    .interrupt_out              (int_out),
    .latch_in_service           (latch),
    .acknowledged_level         (ack_level),
    .end_of_interrupt           (eoi_out),
    .vector_out                 (vec),
    .vector_valid               (vec_valid),
    .rotate_update              (rot_upd),
    .new_priority_rotate        (new_rot)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] irr;
    logic [7:0] mask;
    logic [7:0] isr;
    logic [2:0] rot;
    logic       smm;
    logic [4:0] base;
    int         exp_lvl;   // -1: no interrupt expected
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Distance below the top of the priority order: 0 = highest priority.
  function automatic int rank_of(input int l, input int rt);
    return (l - rt + 7) % 8;
  endfunction

  function automatic int model_winner(input logic [7:0] r, input logic [7:0] m,
                                      input logic [7:0] s, input logic [2:0] rt,
                                      input logic sm);
    int best, best_rank, isr_rank;
    logic [7:0] c;
    logic ok;
    c = r & ~m;
    best = -1;
    best_rank = 8;
    isr_rank = 8;
    for (int l = 0; l < 8; l++)
      if (s[l] && rank_of(l, int'(rt)) < isr_rank) isr_rank = rank_of(l, int'(rt));
    for (int l = 0; l < 8; l++) begin
      ok = sm ? !s[l] : (rank_of(l, int'(rt)) < isr_rank);
      if (c[l] && ok && rank_of(l, int'(rt)) < best_rank) begin
        best = l;
        best_rank = rank_of(l, int'(rt));
      end
    end
    return best;
  endfunction

  function automatic int model_ns_eoi(input logic [7:0] s, input logic [2:0] rt);
    int best, best_rank;
    best = -1;
    best_rank = 8;
    for (int l = 0; l < 8; l++)
      if (s[l] && rank_of(l, int'(rt)) < best_rank) begin
        best = l;
        best_rank = rank_of(l, int'(rt));
      end
    return best;
  endfunction

  task automatic idle_settle();
    irr = 8'h00;
    inta_n = 1'b1;
    eoi_cmd = 1'b0;
    repeat (3) tick();
  endtask

  // Full INTA handshake; lvl < 0 means spurious. Optionally fires a specific
  // EOI (level 1, with rotate) on the same edge as the closing INTA rise.
  task automatic run_ack(input string tag, input int lvl, input logic [4:0] base,
                         input bit cmd_at_rise);
    logic [2:0] l3;
    logic [7:0] ev;
    l3 = (lvl < 0) ? 3'd7 : 3'(lvl);
    ev = {base, l3};
    inta_n = 1'b0;
    tick();
    check({tag, " latch"}, 32'(latch), 32'(lvl >= 0));
    if (lvl >= 0) check({tag, " ack_level"}, 32'(ack_level), 32'(8'd1 << l3));
    check({tag, " int_after_ack1"}, 32'(int_out), 0);
    inta_n = 1'b1;
    tick();
    check({tag, " latch_one_cycle"}, 32'(latch), 0);
    check({tag, " valid_in_ack1"}, 32'(vec_valid), 0);
    inta_n = 1'b0;
    tick();
    check({tag, " valid_in_ack2"}, 32'(vec_valid), 1);
    check({tag, " vector"}, 32'(vec), 32'(ev));
    inta_n = 1'b1;
    if (cmd_at_rise) begin
      eoi_cmd = 1'b1;
      eoi_spec = 1'b1;
      eoi_lvl = 3'd1;
      eoi_rot = 1'b1;
    end
    tick();
    eoi_cmd = 1'b0;
    check({tag, " valid_after_rise"}, 32'(vec_valid), 0);
  endtask

  // Applies one arbitration case and, if an interrupt is expected, acknowledges it.
  task automatic apply_case(input string tag, input vec_t v);
    idle_settle();
    irr = v.irr; mask = v.mask; isr = v.isr; rot = v.rot; smm = v.smm; vbase = v.base;
    tick();
    check({tag, " int_cycle1"}, 32'(int_out), 0);
    tick();
    check({tag, " int_cycle2"}, 32'(int_out), 32'(v.exp_lvl >= 0));
    if (v.exp_lvl >= 0) run_ack(tag, v.exp_lvl, v.base, 1'b0);
  endtask

  task automatic eoi_pulse(input string tag, input logic [7:0] s, input logic [2:0] rt,
                           input logic sp, input logic [2:0] lv, input logic rr);
    int ns;
    logic [7:0] exp_clr;
    logic exp_upd;
    logic [2:0] exp_new;
    isr = s; rot = rt;
    eoi_cmd = 1'b1; eoi_spec = sp; eoi_lvl = lv; eoi_rot = rr;
    if (sp) begin
      exp_clr = 8'd1 << lv; exp_upd = rr; exp_new = lv;
    end else begin
      ns = model_ns_eoi(s, rt);
      if (ns < 0) begin
        exp_clr = 8'h00; exp_upd = 1'b0; exp_new = 3'd0;
      end else begin
        exp_clr = 8'd1 << ns; exp_upd = rr; exp_new = 3'(ns);
      end
    end
    tick();
    eoi_cmd = 1'b0;
    check({tag, " eoi"}, 32'(eoi_out), 32'(exp_clr));
    check({tag, " rot_upd"}, 32'(rot_upd), 32'(exp_upd));
    if (exp_upd) check({tag, " new_rot"}, 32'(new_rot), 32'(exp_new));
    tick();
    check({tag, " eoi_one_cycle"}, 32'(eoi_out), 0);
    check({tag, " rot_one_cycle"}, 32'(rot_upd), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int w;

    tbl[0] = '{8'h04, 8'h00, 8'h00, 3'd7, 1'b0, 5'h08, 2};
    tbl[1] = '{8'h09, 8'h00, 8'h00, 3'd2, 1'b0, 5'h08, 3};
    tbl[2] = '{8'h09, 8'h00, 8'h00, 3'd7, 1'b0, 5'h08, 0};
    tbl[3] = '{8'h08, 8'h00, 8'h02, 3'd7, 1'b0, 5'h08, -1};
    tbl[4] = '{8'h08, 8'h00, 8'h02, 3'd7, 1'b1, 5'h08, 3};
    tbl[5] = '{8'hFF, 8'hFF, 8'h00, 3'd4, 1'b0, 5'h11, -1};
    tbl[6] = '{8'h81, 8'h01, 8'h00, 3'd3, 1'b0, 5'h1F, 7};
    tbl[7] = '{8'h08, 8'h00, 8'h08, 3'd7, 1'b0, 5'h08, -1};
    tbl[8] = '{8'h0C, 8'h00, 8'h08, 3'd7, 1'b0, 5'h02, 2};

    reset_n = 1'b0;
    irr = 0; mask = 0; isr = 0; rot = 3'd7; smm = 0; aeoi = 0; arot = 0; vbase = 5'h08;
    inta_n = 1'b1; eoi_cmd = 0; eoi_spec = 0; eoi_lvl = 0; eoi_rot = 0;
    #1;
    check("reset int", 32'(int_out), 0);
    check("reset latch", 32'(latch), 0);
    check("reset ack", 32'(ack_level), 0);
    check("reset eoi", 32'(eoi_out), 0);
    check("reset vector", 32'(vec), 0);
    check("reset valid", 32'(vec_valid), 0);
    check("reset rot_upd", 32'(rot_upd), 0);
    check("reset new_rot", 32'(new_rot), 0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    // Directed arbitration table.
    for (int i = 0; i < 9; i++) apply_case($sformatf("tbl%0d", i), tbl[i]);

    // Automatic EOI with rotation.
    idle_settle();
    aeoi = 1; arot = 1; irr = 8'h20; mask = 0; isr = 0; rot = 3'd7; smm = 0; vbase = 5'h08;
    tick(); tick();
    check("aeoi int", 32'(int_out), 1);
    run_ack("aeoi", 5, 5'h08, 1'b0);
    check("aeoi eoi", 32'(eoi_out), 32'h20);
    check("aeoi rot_upd", 32'(rot_upd), 1);
    check("aeoi new_rot", 32'(new_rot), 5);
    tick();
    check("aeoi eoi_one_cycle", 32'(eoi_out), 0);
    check("aeoi rot_one_cycle", 32'(rot_upd), 0);

    // Automatic EOI coinciding with a specific rotating EOI command.
    idle_settle();
    irr = 8'h20;
    tick(); tick();
    run_ack("aeoi_cmd", 5, 5'h08, 1'b1);
    check("aeoi_cmd eoi", 32'(eoi_out), 32'h22);
    check("aeoi_cmd rot_upd", 32'(rot_upd), 1);
    check("aeoi_cmd new_rot", 32'(new_rot), 1);

    // Request withdrawn on the first INTA: spurious level, no latch, no AEOI.
    idle_settle();
    irr = 8'h10; rot = 3'd7;
    tick(); tick();
    check("spur int", 32'(int_out), 1);
    irr = 8'h00;
    run_ack("spur", -1, 5'h08, 1'b0);
    check("spur no_aeoi", 32'(eoi_out), 0);
    tick();
    eoi_pulse("ns_empty", 8'h00, 3'd7, 1'b0, 3'd0, 1'b1);
    aeoi = 0; arot = 0;

    // Reset asserted in the middle of the vector cycle.
    idle_settle();
    irr = 8'h04; rot = 3'd7;
    tick(); tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    check("rst_ack2 valid_before", 32'(vec_valid), 1);
    reset_n = 1'b0;
    #1;
    check("rst_ack2 valid", 32'(vec_valid), 0);
    check("rst_ack2 vector", 32'(vec), 0);
    check("rst_ack2 int", 32'(int_out), 0);
    check("rst_ack2 ack", 32'(ack_level), 0);
    inta_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_ack2 idle_int_low", 32'(int_out), 0);
    tick();
    check("rst_ack2 rearm_int", 32'(int_out), 1);
    idle_settle();
    eoi_pulse("ns_14", 8'h14, 3'd7, 1'b0, 3'd0, 1'b0);

    // Randomized arbitration and EOI commands against the model.
    for (int k = 0; k < 40; k++) begin
      rv.irr  = 8'($urandom);
      rv.mask = 8'($urandom) & 8'($urandom);
      rv.isr  = 8'($urandom) & 8'($urandom);
      rv.rot  = 3'($urandom_range(7));
      rv.smm  = 1'($urandom_range(1));
      rv.base = 5'($urandom);
      w = model_winner(rv.irr, rv.mask, rv.isr, rv.rot, rv.smm);
      rv.exp_lvl = w;
      apply_case($sformatf("rnd%0d", k), rv);
      idle_settle();
      eoi_pulse($sformatf("rnd_eoi%0d", k), 8'($urandom) & 8'($urandom),
                3'($urandom_range(7)), 1'($urandom_range(1)),
                3'($urandom_range(7)), 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
